// File: rtl/barrel_coord_gen.sv
// Raster-scan source-coordinate generator for barrel projection.
// Walks the output frame row-major and bends the source row parabolically in column.
package barrel_coord_gen_pkg;
    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
    } sideband_t;
endpackage

module barrel_coord_gen
    import barrel_coord_gen_pkg::*;
#(
    parameter int unsigned OUT_WIDTH   = 1080,
    parameter int unsigned OUT_HEIGHT  = 960,
    parameter int unsigned CENTER_X    = 540,
    parameter int unsigned CURVE_SHIFT = 13,
    parameter int unsigned MAX_CURVE   = 48,
    parameter int unsigned PIPE_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Enable,
    input  logic        Math_Ready,
    input  logic        AXIS_Out_Ready,
    output logic [11:0] Math_X,
    output logic [11:0] Math_Y,
    output logic        Out_Valid,
    output logic        Out_SOF,
    output logic        Out_EOL,
    output logic        Frame_Done
);
    localparam int unsigned COORD_W = 12;
    localparam int unsigned DX_MAX  = (CENTER_X > OUT_WIDTH - CENTER_X) ? CENTER_X : OUT_WIDTH - CENTER_X;
    localparam int unsigned DX_W    = $clog2(DX_MAX + 1);
    localparam int unsigned DX2_W   = 2 * DX_W + 1;
    localparam int unsigned COL_W   = $clog2(OUT_WIDTH);
    localparam int unsigned ROW_W   = $clog2(OUT_HEIGHT);
    localparam int unsigned CX2     = CENTER_X * CENTER_X;

    typedef enum logic [1:0] {IDLE, WAIT_FILL, RUN} state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [DX_W-1:0]    dx;
    logic [DX2_W-1:0]   dx2;
    sideband_t          sb_pipe [PIPE_LAT];
    sideband_t          sb_push;
    logic               issue;
    logic               last_col;
    logic               last_pix;
    logic [DX2_W-1:0]   dx_ext;
    logic [DX2_W-1:0]   curve_raw;
    logic [COORD_W-1:0] curve;

    assign issue     = (state == RUN) && Math_Ready && AXIS_Out_Ready;
    assign last_col  = (col == COL_W'(OUT_WIDTH - 1));
    assign last_pix  = last_col && (row == ROW_W'(OUT_HEIGHT - 1));
    assign dx_ext    = DX2_W'(dx);
    assign curve_raw = dx2 >> CURVE_SHIFT;
    assign curve     = (curve_raw > DX2_W'(MAX_CURVE)) ? COORD_W'(MAX_CURVE) : COORD_W'(curve_raw);
    assign Math_X    = COORD_W'(col);
    assign Math_Y    = COORD_W'(row) + curve;

    // Frame walk; dx2 tracks (col-CENTER_X)^2 by first differences.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            dx         <= DX_W'(CENTER_X);
            dx2        <= DX2_W'(CX2);
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= issue && last_pix;
            case (state)
                IDLE:      if (Enable) state <= WAIT_FILL;
                WAIT_FILL: if (Math_Ready) state <= RUN;
                RUN: begin
                    if (issue && last_pix) state <= Enable ? WAIT_FILL : IDLE;
                    else if (!Math_Ready)  state <= WAIT_FILL;
                end
                default:   state <= IDLE;
            endcase
            if (issue) begin
                if (last_col) begin
                    col <= '0;
                    dx  <= DX_W'(CENTER_X);
                    dx2 <= DX2_W'(CX2);
                    row <= last_pix ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                    if (col < COL_W'(CENTER_X)) begin
                        dx2 <= dx2 - ((dx_ext << 1) - DX2_W'(1));
                        dx  <= dx - DX_W'(1);
                    end else begin
                        dx2 <= dx2 + (dx_ext << 1) + DX2_W'(1);
                        dx  <= dx + DX_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        sb_push = '0;
        if (issue) begin
            sb_push.valid = 1'b1;
            sb_push.sof   = (col == '0) && (row == '0);
            sb_push.eol   = last_col;
        end
    end

    // Sideband delay line, frozen together with the memory interface while downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) sb_pipe[i] <= '0;
        end else if (AXIS_Out_Ready) begin
            sb_pipe[0] <= sb_push;
            for (int unsigned i = 1; i < PIPE_LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
        end
    end

    assign Out_Valid = sb_pipe[PIPE_LAT-1].valid;
    assign Out_SOF   = sb_pipe[PIPE_LAT-1].sof;
    assign Out_EOL   = sb_pipe[PIPE_LAT-1].eol;
endmodule
